// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell shared by two requesters
// under round-robin arbitration, LSB-first sequencing, valid/ready result port.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// state | meaning
// IDLE  | arbitrate and accept one request
// RUN   | one operand bit per clock through the full adder
// DONE  | result presented until res_ready
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_ovf,
  output logic             res_id,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_res_carry;
  logic             r_res_ovf;
  logic             r_id;
  logic             r_last_id;
  logic             r_busy;

  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_fa_sum;
  logic w_fa_cout;
  logic w_last_bit;

  // Tie goes to whichever requester was not served most recently.
  assign w_grant0   = req0_valid & (~req1_valid | r_last_id);
  assign w_grant1   = req1_valid & (~req0_valid | ~r_last_id);
  assign req0_ready = (r_state == S_IDLE) & w_grant0;
  assign req1_ready = (r_state == S_IDLE) & w_grant1;
  assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_last_bit = (r_cnt == LAST_BIT);

  full_adder u_fa (
    .a   (r_a[r_cnt]),
    .b   (r_b[r_cnt]),
    .cin (r_carry),
    .sum (w_fa_sum),
    .cout(w_fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_next_state = S_RUN;
      S_RUN:   if (w_last_bit) w_next_state = S_DONE;
      S_DONE:  if (res_ready)  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_res_carry <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_id        <= 1'b0;
      r_last_id   <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Subtract is a + ~b + 1: invert b here, seed carry with 1.
            r_a         <= w_grant1 ? req1_a : req0_a;
            r_b         <= w_grant1 ? (req1_sub ? ~req1_b : req1_b)
                                    : (req0_sub ? ~req0_b : req0_b);
            r_carry     <= w_grant1 ? req1_sub : req0_sub;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_res_carry <= 1'b0;
            r_res_ovf   <= 1'b0;
            r_id        <= w_grant1;
            r_last_id   <= w_grant1;
            r_busy      <= 1'b1;
          end
        end
        S_RUN: begin
          r_sum[r_cnt] <= w_fa_sum;
          r_carry      <= w_fa_cout;
          r_cnt        <= r_cnt + CW'(1);
          if (w_last_bit) begin
            // r_carry still holds the carry into the MSB at this point.
            r_res_carry <= w_fa_cout;
            r_res_ovf   <= r_carry ^ w_fa_cout;
          end
        end
        S_DONE: begin
          if (res_ready) r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (r_state == S_DONE);
  assign res_sum   = r_sum;
  assign res_carry = r_res_carry;
  assign res_ovf   = r_res_ovf;
  assign res_id    = r_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8): arithmetic,
// boundaries, round-robin contention, backpressure and mid-operation reset.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_sub, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_sub, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_carry, res_ovf, res_id, busy;
  logic [W-1:0] res_sum;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_sub  (req0_sub),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_sub  (req1_sub),
    .req1_ready(req1_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_ovf   (res_ovf),
    .res_id    (res_id),
    .busy      (busy)
  );

  // Drive one request, wait for the result (bounded) and consume it.
  // lat is the number of edges from accept to res_valid, -1 on timeout.
  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, output logic [W-1:0] s, output logic c,
                       output logic v, output logic rid, output int lat);
    res_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~req0_a; req0_b = ~req0_b; req1_a = ~req1_a; req1_b = ~req1_b;
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid) lat = -1;
    s = res_sum; c = res_carry; v = res_ovf; rid = res_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    res_ready = 1'b0;
    #2;
    n_total++;
    if ({res_valid, res_sum, res_carry, res_ovf, res_id, busy} !== '0)
      $display("FAIL reset_outputs: got valid=%b sum=%h c=%b v=%b id=%b busy=%b want all 0",
               res_valid, res_sum, res_carry, res_ovf, res_id, busy);
    else n_pass++;
    n_total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL reset_ready: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
    else n_pass++;
    req0_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0 || res_valid !== 1'b0)
      $display("FAIL reset_release: got busy=%b valid=%b want 0 0", busy, res_valid);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [W-1:0] s; logic c, v, rid; int lat;
    do_op(1'b0, 8'h3C, 8'h0F, 1'b0, s, c, v, rid, lat);
    n_total++;
    if (lat !== 8) $display("FAIL add_latency: got %0d want 8", lat); else n_pass++;
    n_total++;
    if (s !== 8'h4B || c !== 1'b0 || v !== 1'b0 || rid !== 1'b0)
      $display("FAIL add_result: got sum=%h c=%b v=%b id=%b want sum=4b c=0 v=0 id=0",
               s, c, v, rid);
    else n_pass++;
    n_total++;
    if (res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL add_consume: got valid=%b busy=%b want 0 0", res_valid, busy);
    else n_pass++;
  endtask

  task automatic run_table(input string name, input vec_t tbl[$]);
    logic [W-1:0] s; logic c, v, rid; int lat;
    foreach (tbl[i]) begin
      do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sub, s, c, v, rid, lat);
      n_total++;
      if (lat !== 8 || s !== tbl[i].s || c !== tbl[i].c || v !== tbl[i].v || rid !== tbl[i].id)
        $display("FAIL %s[%0d]: got lat=%0d sum=%h c=%b v=%b id=%b want lat=8 sum=%h c=%b v=%b id=%b",
                 name, i, lat, s, c, v, rid, tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].id);
      else n_pass++;
    end
  endtask

  task automatic test_subtract();
    vec_t tbl[$];
    tbl.push_back('{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1});
    run_table("sub", tbl);
  endtask

  task automatic test_add_boundaries();
    vec_t tbl[$];
    tbl.push_back('{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
    run_table("bound", tbl);
  endtask

  task automatic test_contention();
    int           gcyc[$];
    logic         gid[$];
    logic [W-1:0] rsum[$];
    logic         rid[$];
    int           both = 0;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h02; req1_b = 8'h02; req1_sub = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (req0_ready && req1_ready) both++;
      if (req0_ready) begin gcyc.push_back(cyc); gid.push_back(1'b0); end
      if (req1_ready) begin gcyc.push_back(cyc); gid.push_back(1'b1); end
      if (res_valid) begin rsum.push_back(res_sum); rid.push_back(res_id); end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_total++;
    if (both !== 0) $display("FAIL rr_both_ready: got %0d cycles want 0", both); else n_pass++;
    n_total++;
    if (gcyc.size() !== 5) $display("FAIL rr_grant_count: got %0d want 5", gcyc.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < gcyc.size(); i++) begin
      n_total++;
      if (gid[i] !== 1'(i % 2) || gcyc[i] !== 10 * i)
        $display("FAIL rr_grant[%0d]: got id=%b cycle=%0d want id=%0d cycle=%0d",
                 i, gid[i], gcyc[i], i % 2, 10 * i);
      else n_pass++;
    end
    n_total++;
    if (rsum.size() !== 4) $display("FAIL rr_result_count: got %0d want 4", rsum.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < rsum.size(); i++) begin
      n_total++;
      if (rid[i] !== 1'(i % 2) || rsum[i] !== ((i % 2) ? 8'h04 : 8'h02))
        $display("FAIL rr_result[%0d]: got id=%b sum=%h want id=%0d sum=%h",
                 i, rid[i], rsum[i], i % 2, (i % 2) ? 8'h04 : 8'h02);
      else n_pass++;
    end
    // Drain the operation granted at the end of the window.
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int wait_cyc = 0;
    res_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h07; req1_sub = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    while (!res_valid && wait_cyc < 40) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    n_total++;
    if (wait_cyc !== 8) $display("FAIL bp_latency: got %0d want 8", wait_cyc); else n_pass++;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (res_valid !== 1'b1 || res_sum !== 8'hFE || res_carry !== 1'b0 || res_ovf !== 1'b0 ||
          res_id !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL bp_hold[%0d]: got v=%b s=%h c=%b o=%b id=%b r0=%b r1=%b busy=%b want v=1 s=fe c=0 o=0 id=1 r0=0 r1=0 busy=1",
                 i, res_valid, res_sum, res_carry, res_ovf, res_id, req0_ready, req1_ready, busy);
      else n_pass++;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_release: got valid=%b busy=%b want 0 0", res_valid, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s; logic c, v, rid; int lat;
    int seen = 0;
    res_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55; req1_sub = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if (busy !== 1'b1 || res_sum !== 8'h07)
      $display("FAIL mid_run_partial: got busy=%b sum=%h want busy=1 sum=07", busy, res_sum);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({res_valid, res_sum, res_carry, res_ovf, res_id, busy, req0_ready, req1_ready} !== '0)
      $display("FAIL mid_run_reset: got valid=%b sum=%h c=%b v=%b id=%b busy=%b r0=%b r1=%b want all 0",
               res_valid, res_sum, res_carry, res_ovf, res_id, busy, req0_ready, req1_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (res_valid) seen++;
      @(posedge clk); #1;
    end
    n_total++;
    if (seen !== 0) $display("FAIL mid_run_no_result: got %0d valid cycles want 0", seen);
    else n_pass++;
    do_op(1'b0, 8'h12, 8'h34, 1'b0, s, c, v, rid, lat);
    n_total++;
    if (lat !== 8 || s !== 8'h46 || c !== 1'b0 || v !== 1'b0 || rid !== 1'b0)
      $display("FAIL post_reset_add: got lat=%0d sum=%h c=%b v=%b id=%b want lat=8 sum=46 c=0 v=0 id=0",
               lat, s, c, v, rid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_subtract();
    test_add_boundaries();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
